// File: rtl/mem_responder.sv
// Data-memory responder: accepts one load/store at a time, performs a byte-masked
// access to an internal word RAM after a fixed latency, and returns a registered response.
module mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_wen,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wmask,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned IdxW      = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SpanBytes = 32'(DEPTH_WORDS * 4);
  localparam logic [3:0]  CntInit   = 4'(LATENCY - 1);
  localparam bit          SingleCyc = (LATENCY == 1);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state;
  logic [3:0]  cnt;
  logic [31:0] lat_addr;
  logic        lat_wen;
  logic [31:0] lat_wdata;
  logic [3:0]  lat_wmask;

  logic [31:0] mem [DEPTH_WORDS];

  // With a single-cycle latency the access happens at acceptance, so it uses the live inputs.
  logic [31:0] acc_addr;
  logic        acc_wen;
  logic [31:0] acc_wdata;
  logic [3:0]  acc_wmask;
  logic [31:0] offset;
  logic        in_range;
  logic [IdxW-1:0] idx;
  logic        do_access;
  logic [31:0] rd_result;

  always_comb begin
    acc_addr  = SingleCyc ? req_addr  : lat_addr;
    acc_wen   = SingleCyc ? req_wen   : lat_wen;
    acc_wdata = SingleCyc ? req_wdata : lat_wdata;
    acc_wmask = SingleCyc ? req_wmask : lat_wmask;
    offset    = acc_addr - BASE_ADDR;
    in_range  = offset < SpanBytes;
    idx       = offset[IdxW+1:2];
    rd_result = (acc_wen || !in_range) ? 32'h0 : mem[idx];
    do_access = 1'b0;
    if (SingleCyc) begin
      do_access = (state == StIdle) && req_valid;
    end else begin
      do_access = (state == StWait) && (cnt == 4'd1);
    end
  end

  assign req_ready = (state == StIdle) && !rst;

  // RAM is deliberately not reset; a reset on the access edge drops the write.
  always_ff @(posedge clk) begin
    if (!rst && do_access && acc_wen && in_range) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_wmask[i]) begin
          mem[idx][8*i +: 8] <= acc_wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= StIdle;
      cnt       <= 4'd0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
      lat_addr  <= 32'h0;
      lat_wen   <= 1'b0;
      lat_wdata <= 32'h0;
      lat_wmask <= 4'h0;
    end else begin
      case (state)
        StIdle: begin
          if (req_valid) begin
            lat_addr  <= req_addr;
            lat_wen   <= req_wen;
            lat_wdata <= req_wdata;
            lat_wmask <= req_wmask;
            cnt       <= CntInit;
            if (SingleCyc) begin
              state     <= StResp;
              rsp_valid <= 1'b1;
              rsp_rdata <= rd_result;
              rsp_err   <= !in_range;
            end else begin
              state <= StWait;
            end
          end
        end
        StWait: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state     <= StResp;
            rsp_valid <= 1'b1;
            rsp_rdata <= rd_result;
            rsp_err   <= !in_range;
          end
        end
        StResp: begin
          if (rsp_ready) begin
            state     <= StIdle;
            rsp_valid <= 1'b0;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances (latency 2, 1, 4) driven from a vector table
// and hand sequences, responses checked against a scoreboard queue.
module tb_mem_responder;

  localparam int NDUT = 3;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst       [NDUT];
  logic        req_valid [NDUT];
  logic        req_ready [NDUT];
  logic [31:0] req_addr  [NDUT];
  logic        req_wen   [NDUT];
  logic [31:0] req_wdata [NDUT];
  logic [3:0]  req_wmask [NDUT];
  logic        rsp_valid [NDUT];
  logic        rsp_ready [NDUT];
  logic [31:0] rsp_rdata [NDUT];
  logic        rsp_err   [NDUT];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    mem_responder #(
      .DEPTH_WORDS(1024),
      .BASE_ADDR  (32'h8000_0000),
      .LATENCY    (g == 0 ? 2 : (g == 1 ? 1 : 4))
    ) u_dut (
      .clk      (clk),
      .rst      (rst[g]),
      .req_valid(req_valid[g]),
      .req_ready(req_ready[g]),
      .req_addr (req_addr[g]),
      .req_wen  (req_wen[g]),
      .req_wdata(req_wdata[g]),
      .req_wmask(req_wmask[g]),
      .rsp_valid(rsp_valid[g]),
      .rsp_ready(rsp_ready[g]),
      .rsp_rdata(rsp_rdata[g]),
      .rsp_err  (rsp_err[g])
    );
  end

  function automatic int lat_of(input int d);
    return (d == 0) ? 2 : ((d == 1) ? 1 : 4);
  endfunction

  int total  = 0;
  int passed = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask

  typedef struct {
    int          dut;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sbq[$];

  // Scoreboard monitor: compare at every response handshake.
  always begin
    exp_t e;
    @(negedge clk);
    #1;
    for (int d = 0; d < NDUT; d++) begin
      if (rsp_valid[d] === 1'b1 && rsp_ready[d] === 1'b1) begin
        if (sbq.size() == 0) begin
          check("rsp with empty scoreboard", {31'b0, rsp_valid[d]}, 32'h0);
        end else begin
          e = sbq.pop_front();
          check("rsp dut", d, e.dut);
          check("rsp_rdata", rsp_rdata[d], e.rdata);
          check("rsp_err", {31'b0, rsp_err[d]}, {31'b0, e.err});
        end
      end
    end
  end

  // Issue one request, push its expected response, then measure latency to rsp_valid.
  task automatic issue(input int d, input logic [31:0] a, input logic w, input logic [31:0] wd,
                       input logic [3:0] m, input logic [31:0] er, input logic ee);
    int n;
    req_valid[d] = 1'b1;
    req_addr[d]  = a;
    req_wen[d]   = w;
    req_wdata[d] = wd;
    req_wmask[d] = m;
    n = 0;
    while (req_ready[d] !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      check("req_ready timeout", {31'b0, req_ready[d]}, 32'h1);
      req_valid[d] = 1'b0;
      return;
    end
    sbq.push_back('{dut: d, rdata: er, err: ee});
    @(negedge clk);
    // Scramble request fields: they must have been sampled at acceptance.
    req_valid[d] = 1'b0;
    req_addr[d]  = ~a;
    req_wen[d]   = ~w;
    req_wdata[d] = ~wd;
    req_wmask[d] = ~m;
    n = 1;
    while (rsp_valid[d] !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("latency", n, lat_of(d));
  endtask

  typedef struct {
    int          dut;
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          n;
    int          acc [3];
    logic [31:0] ba  [3];

    vecs.push_back('{0, 32'h8000_0010, 1'b1, 32'hDEAD_BEEF, 4'hF, 32'h0,         1'b0});
    vecs.push_back('{0, 32'h8000_0010, 1'b0, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0});
    vecs.push_back('{0, 32'h8000_0020, 1'b1, 32'h1122_3344, 4'hF, 32'h0,         1'b0});
    vecs.push_back('{0, 32'h8000_0020, 1'b1, 32'h0000_AA00, 4'h2, 32'h0,         1'b0});
    vecs.push_back('{0, 32'h8000_0022, 1'b0, 32'h0,         4'h0, 32'h1122_AA44, 1'b0});
    vecs.push_back('{0, 32'h8000_0FFC, 1'b1, 32'hCAFE_F00D, 4'hF, 32'h0,         1'b0});
    vecs.push_back('{0, 32'h8000_0000, 1'b1, 32'hA5A5_A5A5, 4'hF, 32'h0,         1'b0});
    vecs.push_back('{0, 32'h7FFF_FFFC, 1'b0, 32'h0,         4'h0, 32'h0,         1'b1});
    vecs.push_back('{0, 32'h8000_1000, 1'b1, 32'hFFFF_FFFF, 4'hF, 32'h0,         1'b1});
    vecs.push_back('{0, 32'h8000_0FFC, 1'b0, 32'h0,         4'h0, 32'hCAFE_F00D, 1'b0});
    vecs.push_back('{0, 32'h8000_0000, 1'b0, 32'h0,         4'h0, 32'hA5A5_A5A5, 1'b0});
    vecs.push_back('{0, 32'h8000_0000, 1'b1, 32'hFFFF_FFFF, 4'h0, 32'h0,         1'b0});
    vecs.push_back('{0, 32'h8000_0001, 1'b0, 32'h0,         4'h0, 32'hA5A5_A5A5, 1'b0});
    vecs.push_back('{0, 32'h8000_0FFF, 1'b1, 32'h9900_0000, 4'h8, 32'h0,         1'b0});
    vecs.push_back('{0, 32'h8000_0FFD, 1'b0, 32'h0,         4'h0, 32'h99FE_F00D, 1'b0});
    vecs.push_back('{0, 32'h0000_0010, 1'b0, 32'h0,         4'h0, 32'h0,         1'b1});
    vecs.push_back('{1, 32'h8000_0100, 1'b1, 32'h0000_0001, 4'hF, 32'h0,         1'b0});
    vecs.push_back('{1, 32'h8000_0104, 1'b1, 32'h0000_0002, 4'hF, 32'h0,         1'b0});
    vecs.push_back('{1, 32'h8000_0108, 1'b1, 32'h0000_0003, 4'hF, 32'h0,         1'b0});
    vecs.push_back('{1, 32'h8000_0104, 1'b0, 32'h0,         4'h0, 32'h0000_0002, 1'b0});
    vecs.push_back('{2, 32'h8000_0040, 1'b1, 32'h0,         4'hF, 32'h0,         1'b0});
    vecs.push_back('{2, 32'h8000_0040, 1'b0, 32'h0,         4'h0, 32'h0,         1'b0});

    for (int d = 0; d < NDUT; d++) begin
      rst[d]       = 1'b1;
      req_valid[d] = 1'b0;
      req_addr[d]  = 32'h0;
      req_wen[d]   = 1'b0;
      req_wdata[d] = 32'h0;
      req_wmask[d] = 4'h0;
      rsp_ready[d] = 1'b1;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      check("reset req_ready", {31'b0, req_ready[d]}, 32'h0);
      check("reset rsp_valid", {31'b0, rsp_valid[d]}, 32'h0);
      check("reset rsp_rdata", rsp_rdata[d], 32'h0);
      check("reset rsp_err", {31'b0, rsp_err[d]}, 32'h0);
    end
    for (int d = 0; d < NDUT; d++) rst[d] = 1'b0;
    @(negedge clk);
    for (int d = 0; d < NDUT; d++) check("idle req_ready", {31'b0, req_ready[d]}, 32'h1);

    foreach (vecs[i]) begin
      issue(vecs[i].dut, vecs[i].addr, vecs[i].wen, vecs[i].wdata, vecs[i].wmask,
            vecs[i].rdata, vecs[i].err);
    end
    @(negedge clk);

    // Backpressure: response must hold while rsp_ready is low.
    rsp_ready[0] = 1'b0;
    issue(0, 32'h8000_0010, 1'b0, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0);
    for (int k = 0; k < 3; k++) begin
      check("bp rsp_valid", {31'b0, rsp_valid[0]}, 32'h1);
      check("bp rsp_rdata", rsp_rdata[0], 32'hDEAD_BEEF);
      check("bp req_ready", {31'b0, req_ready[0]}, 32'h0);
      @(negedge clk);
    end
    rsp_ready[0] = 1'b1;
    @(negedge clk);
    check("bp req_ready after hs", {31'b0, req_ready[0]}, 32'h1);
    check("bp rsp_valid after hs", {31'b0, rsp_valid[0]}, 32'h0);

    // Back-to-back loads with req_valid held high on the latency-1 instance.
    ba[0] = 32'h8000_0100;
    ba[1] = 32'h8000_0104;
    ba[2] = 32'h8000_0108;
    req_valid[1] = 1'b1;
    req_wen[1]   = 1'b0;
    for (int k = 0; k < 3; k++) begin
      req_addr[1] = ba[k];
      n = 0;
      while (req_ready[1] !== 1'b1 && n < 20) begin
        @(negedge clk);
        n++;
      end
      acc[k] = cyc;
      sbq.push_back('{dut: 1, rdata: 32'(k + 1), err: 1'b0});
      @(negedge clk);
    end
    req_valid[1] = 1'b0;
    check("b2b spacing 0-1", acc[1] - acc[0], 32'd2);
    check("b2b spacing 1-2", acc[2] - acc[1], 32'd2);
    repeat (2) @(negedge clk);

    // Reset one cycle after accepting a store on the latency-4 instance.
    req_valid[2] = 1'b1;
    req_addr[2]  = 32'h8000_0040;
    req_wen[2]   = 1'b1;
    req_wdata[2] = 32'h5555_5555;
    req_wmask[2] = 4'hF;
    n = 0;
    while (req_ready[2] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    req_valid[2] = 1'b0;
    rst[2]       = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("rst req_ready", {31'b0, req_ready[2]}, 32'h0);
      check("rst rsp_valid", {31'b0, rsp_valid[2]}, 32'h0);
    end
    rst[2] = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("post-rst req_ready", {31'b0, req_ready[2]}, 32'h1);
      check("post-rst rsp_valid", {31'b0, rsp_valid[2]}, 32'h0);
    end
    issue(2, 32'h8000_0040, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);

    repeat (5) @(negedge clk);
    check("scoreboard drained", sbq.size(), 32'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
